pb_input_port: RTL and testbench

Memory-mapped pushbutton input peripheral between the `pb[4:0]` board pins and the CPU data bus inside `top`. Each button is synchronized and debounced. Rising edges of the debounced level are latched as sticky press events. The CPU reads levels and events through a small register file and clears events with write-1-to-clear. An optional level interrupt is raised while any unmasked event is pending.

---
 rtl/pb_pkg.sv | 13 +
 rtl/pb_debounce.sv | 46 ++++
 rtl/pb_input_port.sv | 101 ++++++++++
 tb/tb_pb_input_port.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pb_pkg.sv
// Shared constants for the pushbutton input peripheral.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: register index constants and the CPU data-bus width.
package pb_pkg;

   localparam int PB_DW = 16;

   localparam logic [1:0] PB_REG_LEVEL = 2'd0;
   localparam logic [1:0] PB_REG_EVENT = 2'd1;
   localparam logic [1:0] PB_REG_MASK  = 2'd2;

endpackage : pb_pkg

// File: rtl/pb_debounce.sv
// Single-button two-flop synchronizer followed by a consecutive-cycle debounce counter.
// Latency: a stable input change sampled at edge k reaches level at edge k+1+DEBOUNCE_CYCLES.
// Backpressure: none; free-running per clock.
// Ports: clk, rst_n (async, active-low), pb (raw pin), level (debounced), rise (1-cycle pulse
//        high in the cycle before the edge where level goes 0->1).
module pb_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pb,
   output logic level,
   output logic rise
);

   localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
      end else begin
         s1 <= pb;
         s2 <= s1;
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            level <= s2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Combinational so the parent can latch the event on the same edge level flips.
   assign rise = s2 & ~level & (cnt == LAST);

endmodule : pb_debounce

// File: rtl/pb_input_port.sv
// Memory-mapped pushbutton peripheral: debounced levels, sticky W1C press events, optional irq.
// Latency: reads return in rdata one cycle after the sel read cycle; irq one edge after event/mask.
// Backpressure: none; one bus access accepted every cycle.
// Ports: clk, rst_n (async, active-low), pb[NUM_PB-1:0] raw pins, sel/we/addr/wdata bus request,
//        rdata registered read data, irq level interrupt.
// Build option: define PB_IRQ_EN to include the MASK register and irq; otherwise irq is tied 0.
module pb_input_port
   import pb_pkg::*;
#(
   parameter int NUM_PB          = 5,   // 1..16
   parameter int DEBOUNCE_CYCLES = 4    // >= 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_PB-1:0] pb,
   input  logic              sel,
   input  logic              we,
   input  logic [1:0]        addr,
   input  logic [PB_DW-1:0]  wdata,
   output logic [PB_DW-1:0]  rdata,
   output logic              irq
);

   logic [NUM_PB-1:0] level_v;
   logic [NUM_PB-1:0] rise_v;
   logic [NUM_PB-1:0] evt;
   logic [NUM_PB-1:0] evt_clr;
   logic [PB_DW-1:0]  rd_val;
   logic              wr_vld;
   logic              rd_vld;

   for (genvar i = 0; i < NUM_PB; i++) begin : g_btn
      pb_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .pb    (pb[i]),
         .level (level_v[i]),
         .rise  (rise_v[i])
      );
   end

   assign wr_vld  = sel & we;
   assign rd_vld  = sel & ~we;
   assign evt_clr = (wr_vld && addr == PB_REG_EVENT) ? wdata[NUM_PB-1:0] : '0;

   // Set is OR'd in after the clear so a press coinciding with a W1C survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt <= '0;
      end else begin
         evt <= (evt & ~evt_clr) | rise_v;
      end
   end

`ifdef PB_IRQ_EN
   logic [NUM_PB-1:0] mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask <= '0;
         irq  <= 1'b0;
      end else begin
         if (wr_vld && addr == PB_REG_MASK) begin
            mask <= wdata[NUM_PB-1:0];
         end
         irq <= |(evt & mask);
      end
   end
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      rd_val = '0;
      case (addr)
         PB_REG_LEVEL: rd_val[NUM_PB-1:0] = level_v;
         PB_REG_EVENT: rd_val[NUM_PB-1:0] = evt;
`ifdef PB_IRQ_EN
         PB_REG_MASK:  rd_val[NUM_PB-1:0] = mask;
`endif
         default:      rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (rd_vld) begin
         rdata <= rd_val;
      end
   end

   // Write-data bits above the button count have no destination.
   if (NUM_PB < PB_DW) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^wdata[PB_DW-1:NUM_PB];
   end

endmodule : pb_input_port

// File: tb/tb_pb_input_port.sv
// Self-checking bench for pb_input_port: reads are scoreboarded (expected pushed at issue,
// popped when rdata is valid), irq and reset values are checked directly.
// Works with or without PB_IRQ_EN defined.
module tb_pb_input_port;

   localparam int NB = 5;
   localparam int DC = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NB-1:0] pb;
   logic          sel;
   logic          we;
   logic [1:0]    addr;
   logic [15:0]   wdata;
   logic [15:0]   rdata;
   logic          irq;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] exp_q[$];
   string       tag_q[$];
   logic        rd_pend = 1'b0;

   always #5 clk = ~clk;

   pb_input_port #(
      .NUM_PB          (NB),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pb    (pb),
      .sel   (sel),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   // A read sampled at a posedge has its data in rdata by the following negedge.
   always @(posedge clk) rd_pend <= rst_n & sel & ~we;

   always @(negedge clk) begin
      if (rd_pend) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_read", rdata, 16'hxxxx);
         end else begin
            check_eq(tag_q.pop_front(), rdata, exp_q.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
      sel  = 1'b1;
      we   = 1'b0;
      addr = a;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      tick(1);
      sel = 1'b0;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
      sel   = 1'b1;
      we    = 1'b1;
      addr  = a;
      wdata = d;
      tick(1);
      sel = 1'b0;
      we  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      pb    = 5'b10101;
      sel   = 1'b0;
      we    = 1'b0;
      addr  = 2'd0;
      wdata = 16'h0;

      // Reset held with buttons pressed: outputs stay 0.
      for (int i = 0; i < 15; i++) begin
         tick(1);
         check_eq("rst_rdata", rdata, 16'h0);
         check_eq("rst_irq", {15'h0, irq}, 16'h0);
      end
      rst_n = 1'b1;
      tick(2 + DC + 1);
      bus_rd(2'd0, 16'h0015, "rst_level");
      bus_rd(2'd1, 16'h0015, "rst_event");
      bus_wr(2'd1, 16'h001F);
      bus_rd(2'd1, 16'h0000, "clr_all");

      // Release: falling levels create no events.
      pb = '0;
      tick(10);
      bus_rd(2'd0, 16'h0000, "release_level");
      bus_rd(2'd1, 16'h0000, "release_event");

      // Short glitch on pb[0] is filtered.
      pb[0] = 1'b1;
      tick(3);
      pb[0] = 1'b0;
      tick(10);
      bus_rd(2'd0, 16'h0000, "glitch_level");
      bus_rd(2'd1, 16'h0000, "glitch_event");

      // Held press: level flips exactly at edge k+1+DC.
      pb[0] = 1'b1;
      tick(5);
      bus_rd(2'd0, 16'h0000, "deb_level_early");
      bus_rd(2'd0, 16'h0001, "deb_level_flip");
      bus_rd(2'd1, 16'h0001, "deb_event");

      // W1C and non-destructive reads.
      pb[1] = 1'b1;
      tick(10);
      bus_rd(2'd1, 16'h0003, "w1c_before");
      bus_wr(2'd1, 16'h0001);
      bus_rd(2'd1, 16'h0002, "w1c_rd1");
      bus_rd(2'd1, 16'h0002, "w1c_rd2");
      bus_wr(2'd1, 16'h001F);
      pb = '0;
      tick(10);
      bus_rd(2'd1, 16'h0000, "w1c_after");

      // Collision: clear of bit 2 on the edge it is set; set wins.
      pb[2] = 1'b1;
      tick(5);
      bus_wr(2'd1, 16'h0004);
      bus_rd(2'd1, 16'h0004, "collision");
      bus_wr(2'd1, 16'h0004);
      bus_rd(2'd1, 16'h0000, "collision_clr");

      // Unused register.
      bus_wr(2'd3, 16'hFFFF);
      bus_rd(2'd3, 16'h0000, "reg3");

`ifdef PB_IRQ_EN
      bus_wr(2'd2, 16'h0010);
      bus_rd(2'd2, 16'h0010, "mask_rd");
      pb[4] = 1'b1;
      tick(5);
      check_eq("irq_pre", {15'h0, irq}, 16'h0);
      tick(1);
      check_eq("irq_evt_edge", {15'h0, irq}, 16'h0);
      tick(1);
      check_eq("irq_set", {15'h0, irq}, 16'h1);
      bus_wr(2'd1, 16'h0010);
      check_eq("irq_clr_edge", {15'h0, irq}, 16'h1);
      tick(1);
      check_eq("irq_clr", {15'h0, irq}, 16'h0);
      pb[1] = 1'b1;
      tick(10);
      check_eq("irq_masked", {15'h0, irq}, 16'h0);
      bus_rd(2'd1, 16'h0002, "masked_event");
`else
      bus_wr(2'd2, 16'h0010);
      bus_rd(2'd2, 16'h0000, "mask_absent");
      pb[4] = 1'b1;
      tick(10);
      check_eq("irq_tied", {15'h0, irq}, 16'h0);
      bus_rd(2'd1, 16'h0010, "noirq_event");
`endif
      bus_wr(2'd1, 16'h001F);
      pb = '0;
      tick(10);
      bus_rd(2'd1, 16'h0000, "pre_mid_rst");

      // Reset mid-debounce with pb[3] held through it.
      pb[3] = 1'b1;
      tick(2);
      rst_n = 1'b0;
      tick(2);
      check_eq("mid_rst_rdata", rdata, 16'h0);
      check_eq("mid_rst_irq", {15'h0, irq}, 16'h0);
      rst_n = 1'b1;
      tick(5);
      bus_rd(2'd1, 16'h0000, "mid_rst_evt_early");
      bus_rd(2'd1, 16'h0008, "mid_rst_evt");
      bus_rd(2'd0, 16'h0008, "mid_rst_level");

      tick(3);
      check_eq("sb_drained", 16'(exp_q.size()), 16'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pb_input_port
